latch_q_monitor: RTL and testbench
==================================

Name: latch_q_monitor

Overview:
- Downstream consumer of the D latch outputs Q/Qbar.
- Synchronises the asynchronous latch output pair into its clock domain and tracks the latched level with a small FSM.
- Emits single-cycle rise/fall pulses, counts transitions in saturating counters, and flags a sticky fault when Q and Qbar stay equal too long.
- Sits between the latch and any downstream logic that needs clean, clocked level and edge information.

Parameters:
W, 8, width of the rise and fall transition counters.
ERR_CYCLES, 3, consecutive synchronised cycles with Q==Qbar needed to enter FAULT (must be >=1).

Ports:
C  input  1  clock, rising-edge active.
CLRbar  input  1  asynchronous active-low reset.
Q_in  input  1  latch Q output (asynchronous to C).
Qbar_in  input  1  latch Qbar output (asynchronous to C).
CNT_CLR  input  1  synchronous clear of counters; also the exit from FAULT.
LEVEL  output  1  1 when the FSM is in HIGH, else 0.
RISE  output  1  one-cycle pulse on a LOW->HIGH transition.
FALL  output  1  one-cycle pulse on a HIGH->LOW transition.
RISE_CNT  output  W  saturating count of RISE pulses.
FALL_CNT  output  W  saturating count of FALL pulses.
FAULT  output  1  1 while the FSM is in FAULT.
STATE  output  2  encoded FSM state.

Behaviour:
- Clock and reset: one clock C. Reset is asynchronous and active-low on CLRbar. While CLRbar=0, every flop clears and the outputs read: LEVEL=0, RISE=0, FALL=0, RISE_CNT=0, FALL_CNT=0, FAULT=0, STATE=UNKNOWN. An assertion mid-operation aborts immediately, including in FAULT.
- Synchroniser: two flops per input, both reset to 0, producing sQ and sQb.
  - A pair is valid when sQ != sQb, and invalid when sQ == sQb.
- Latency: a change on Q_in/Qbar_in that is stable before rising edge k is captured at k, appears on sQ after k+1, and updates STATE/LEVEL/RISE/FALL after edge k+2.
- FSM state encoding: UNKNOWN=00, LOW=01, HIGH=10, FAULT=11.
  - UNKNOWN: a valid pair with sQ=1 goes to HIGH; with sQ=0 goes to LOW. No RISE/FALL pulse and no count on this entry.
  - LOW: a valid pair with sQ=1 goes to HIGH, asserts RISE for one cycle and increments RISE_CNT.
  - HIGH: a valid pair with sQ=0 goes to LOW, asserts FALL for one cycle and increments FALL_CNT.
  - Any non-FAULT state on an invalid pair: hold state and increment the mismatch counter (saturates at ERR_CYCLES). When the counter reaches ERR_CYCLES, enter FAULT on that edge.
  - Any valid pair zeroes the mismatch counter.
  - FAULT is sticky. Input activity is ignored and there are no pulses or counts. Exit is only via CNT_CLR=1, which returns to UNKNOWN on the next edge, or via reset.
- Counters: increment only on registered transitions. Each saturates at 2^W-1 and holds there; it never wraps.
- CNT_CLR (synchronous):
  - Zeroes RISE_CNT, FALL_CNT and the mismatch counter.
  - Has priority over an increment in the same cycle. The coincident transition still changes state and still pulses RISE/FALL, but the counter reads 0 afterwards.
  - In non-FAULT states, state evaluation proceeds normally.
- RISE and FALL are never high in the same cycle. Both are registered outputs.
- A pair that goes invalid then valid again within fewer than ERR_CYCLES cycles is tolerated: state resumes from the held value and a transition is taken if sQ differs from LEVEL.

Test Plan:
1. Reset with CLRbar=0, Q_in=1, Qbar_in=0, then release -> STATE=00 until the 3rd edge after release, then STATE=10, LEVEL=1, RISE=0, RISE_CNT=0.
2. From HIGH, toggle Q_in/Qbar_in between (0,1) and (1,0) 4 times, holding each for 10 cycles -> FALL, RISE, FALL, RISE each pulse exactly 1 cycle, 3 edges after each change; final counts FALL_CNT=2, RISE_CNT=2.
3. Drive Q_in=Qbar_in=1 for 2 cycles, then restore a valid pair -> no FAULT, state held, counters unchanged. Hold Q_in=Qbar_in=1 for 3 cycles -> FAULT=1, STATE=11. Further toggles give no pulses and no counts.
4. In FAULT, pulse CNT_CLR for 1 cycle -> STATE=00, both counts 0, FAULT=0. The next valid pair re-enters LOW/HIGH with no pulse.
5. With W=2, generate 5 rises -> RISE_CNT saturates at 3. Assert CNT_CLR in the same cycle as a rise -> RISE=1, RISE_CNT=0.
6. Assert CLRbar=0 asynchronously mid-toggle (between edges) -> all outputs read 0 and STATE=00 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/latch_q_monitor.sv
// latch_q_monitor
// Clocked consumer of an asynchronous D-latch output pair (Q/Qbar).
// Brings the pair into the C domain through a two-flop synchroniser, tracks
// the latched level with a four-state FSM, emits registered one-cycle
// RISE/FALL pulses, keeps saturating transition counters and raises a
// sticky FAULT when the synchronised pair stays equal for ERR_CYCLES cycles.
module latch_q_monitor #(
  parameter int W          = 8,
  parameter int ERR_CYCLES = 3
) (
  input  logic         C,
  input  logic         CLRbar,
  input  logic         Q_in,
  input  logic         Qbar_in,
  input  logic         CNT_CLR,
  output logic         LEVEL,
  output logic         RISE,
  output logic         FALL,
  output logic [W-1:0] RISE_CNT,
  output logic [W-1:0] FALL_CNT,
  output logic         FAULT,
  output logic [1:0]   STATE
);

  // Mismatch counter must be able to hold ERR_CYCLES itself.
  localparam int MW = (ERR_CYCLES < 1) ? 1 : $clog2(ERR_CYCLES + 1);
  localparam logic [MW-1:0] MIS_MAX = MW'(ERR_CYCLES);
  localparam logic [W-1:0]  CNT_MAX = {W{1'b1}};

  typedef enum logic [1:0] {
    ST_UNKNOWN = 2'b00,
    ST_LOW     = 2'b01,
    ST_HIGH    = 2'b10,
    ST_FAULT   = 2'b11
  } state_t;

  // ---------------------------------------------------------------------
  // Two-flop synchroniser, one channel per latch output.
  // Bit 0 carries Q, bit 1 carries Qbar.
  // ---------------------------------------------------------------------
  logic [1:0] async_in;
  logic [1:0] sync_out;

  assign async_in = {Qbar_in, Q_in};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_sync
      logic meta_reg;
      logic sync_reg;

      // Capture stage then stabilising stage; both clear on reset.
      always_ff @(posedge C or negedge CLRbar) begin
        if (!CLRbar) begin
          meta_reg <= 1'b0;
          sync_reg <= 1'b0;
        end else begin
          meta_reg <= async_in[gi];
          sync_reg <= meta_reg;
        end
      end

      assign sync_out[gi] = sync_reg;
    end
  endgenerate

  logic s_q;
  logic s_qb;
  logic pair_valid;

  assign s_q        = sync_out[0];
  assign s_qb       = sync_out[1];
  // A healthy latch always presents complementary outputs.
  assign pair_valid = (s_q != s_qb);

  // ---------------------------------------------------------------------
  // State, pulse and counter registers
  // ---------------------------------------------------------------------
  state_t         state_reg, state_next;
  logic [MW-1:0]  mis_reg, mis_next;
  logic           rise_reg, rise_next;
  logic           fall_reg, fall_next;
  logic [W-1:0]   rise_cnt_reg, rise_cnt_next;
  logic [W-1:0]   fall_cnt_reg, fall_cnt_next;

  // State register and all registered outputs.
  always_ff @(posedge C or negedge CLRbar) begin
    if (!CLRbar) begin
      state_reg    <= ST_UNKNOWN;
      mis_reg      <= '0;
      rise_reg     <= 1'b0;
      fall_reg     <= 1'b0;
      rise_cnt_reg <= '0;
      fall_cnt_reg <= '0;
    end else begin
      state_reg    <= state_next;
      mis_reg      <= mis_next;
      rise_reg     <= rise_next;
      fall_reg     <= fall_next;
      rise_cnt_reg <= rise_cnt_next;
      fall_cnt_reg <= fall_cnt_next;
    end
  end

  // Next-state logic: level tracking, mismatch run length and fault entry.
  always_comb begin
    state_next = state_reg;
    mis_next   = mis_reg;
    rise_next  = 1'b0;
    fall_next  = 1'b0;

    case (state_reg)
      ST_FAULT: begin
        // Sticky: only a counter clear (or reset) leaves FAULT.
        if (CNT_CLR) begin
          state_next = ST_UNKNOWN;
        end
      end

      default: begin
        if (pair_valid) begin
          mis_next = '0;
          case (state_reg)
            ST_UNKNOWN: state_next = s_q ? ST_HIGH : ST_LOW;
            ST_LOW: begin
              if (s_q) begin
                state_next = ST_HIGH;
                rise_next  = 1'b1;
              end
            end
            ST_HIGH: begin
              if (!s_q) begin
                state_next = ST_LOW;
                fall_next  = 1'b1;
              end
            end
            default: state_next = state_reg;
          endcase
        end else begin
          // Invalid pair: hold the level, extend the run, fault at the limit.
          if (mis_reg < MIS_MAX) begin
            mis_next = mis_reg + 1'b1;
          end
          if (mis_next >= MIS_MAX) begin
            state_next = ST_FAULT;
          end
        end
      end
    endcase

    // A clear wins over any run-length update in the same cycle.
    if (CNT_CLR) begin
      mis_next = '0;
    end
  end

  // Transition counters: saturate at all-ones, clear has priority.
  always_comb begin
    rise_cnt_next = rise_cnt_reg;
    fall_cnt_next = fall_cnt_reg;
    if (CNT_CLR) begin
      rise_cnt_next = '0;
      fall_cnt_next = '0;
    end else begin
      if (rise_next && (rise_cnt_reg != CNT_MAX)) begin
        rise_cnt_next = rise_cnt_reg + 1'b1;
      end
      if (fall_next && (fall_cnt_reg != CNT_MAX)) begin
        fall_cnt_next = fall_cnt_reg + 1'b1;
      end
    end
  end

  assign STATE    = state_reg;
  assign LEVEL    = (state_reg == ST_HIGH);
  assign FAULT    = (state_reg == ST_FAULT);
  assign RISE     = rise_reg;
  assign FALL     = fall_reg;
  assign RISE_CNT = rise_cnt_reg;
  assign FALL_CNT = fall_cnt_reg;

endmodule

// File: tb/tb_latch_q_monitor.sv
// tb_latch_q_monitor
// Directed walk through the main scenarios followed by randomized latch
// activity, compared every cycle against a behavioural model of the monitor.
// Two instances run side by side: default counter width and a 2-bit one that
// saturates quickly.
module tb_latch_q_monitor;

  localparam int ERR = 3;

  logic       c;
  logic       clrbar;
  logic       q_in;
  logic       qbar_in;
  logic       cnt_clr;

  logic       level_a, rise_a, fall_a, fault_a;
  logic [7:0] rcnt_a, fcnt_a;
  logic [1:0] state_a;
  logic       level_b, rise_b, fall_b, fault_b;
  logic [1:0] rcnt_b, fcnt_b;
  logic [1:0] state_b;

  latch_q_monitor #(.W(8), .ERR_CYCLES(ERR)) dut_a (
    .C(c), .CLRbar(clrbar), .Q_in(q_in), .Qbar_in(qbar_in), .CNT_CLR(cnt_clr),
    .LEVEL(level_a), .RISE(rise_a), .FALL(fall_a), .RISE_CNT(rcnt_a),
    .FALL_CNT(fcnt_a), .FAULT(fault_a), .STATE(state_a)
  );

  latch_q_monitor #(.W(2), .ERR_CYCLES(ERR)) dut_b (
    .C(c), .CLRbar(clrbar), .Q_in(q_in), .Qbar_in(qbar_in), .CNT_CLR(cnt_clr),
    .LEVEL(level_b), .RISE(rise_b), .FALL(fall_b), .RISE_CNT(rcnt_b),
    .FALL_CNT(fcnt_b), .FAULT(fault_b), .STATE(state_b)
  );

  initial c = 1'b0;
  always #5 c = ~c;

  int n_chk  = 0;
  int n_fail = 0;

  // Single comparison point for the whole bench.
  task automatic check_val(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // ------------------------------------------------------------------
  // Reference model: the monitor sees the input pair two edges late.
  // Level is tracked as "unknown / 0 / 1 / faulted"; the bad-pair run
  // length is just counted and compared with ERR.
  // ------------------------------------------------------------------
  int  m_state;            // 0 unknown, 1 low, 2 high, 3 fault (as STATE encodes)
  int  m_bad;
  int  m_rise, m_fall;
  int  m_rcnt8, m_fcnt8, m_rcnt2, m_fcnt2;
  bit  hist_q[$];
  bit  hist_qb[$];

  task automatic model_reset();
    m_state = 0;
    m_bad   = 0;
    m_rise  = 0;
    m_fall  = 0;
    m_rcnt8 = 0; m_fcnt8 = 0; m_rcnt2 = 0; m_fcnt2 = 0;
    hist_q  = {1'b0, 1'b0};
    hist_qb = {1'b0, 1'b0};
  endtask

  function automatic int sat_inc(input int v, input int maxv);
    return (v >= maxv) ? maxv : v + 1;
  endfunction

  task automatic model_edge();
    bit sq, sqb;
    sq  = hist_q.pop_front();
    sqb = hist_qb.pop_front();
    hist_q.push_back(q_in);
    hist_qb.push_back(qbar_in);
    m_rise = 0;
    m_fall = 0;
    if (m_state == 3) begin
      if (cnt_clr) m_state = 0;
    end else if (sq != sqb) begin
      m_bad = 0;
      if (m_state == 0)              m_state = sq ? 2 : 1;
      else if (m_state == 1 && sq)   begin m_state = 2; m_rise = 1; end
      else if (m_state == 2 && !sq)  begin m_state = 1; m_fall = 1; end
    end else begin
      m_bad = sat_inc(m_bad, ERR);
      if (m_bad >= ERR) m_state = 3;
    end
    if (cnt_clr) begin
      m_bad = 0;
      m_rcnt8 = 0; m_fcnt8 = 0; m_rcnt2 = 0; m_fcnt2 = 0;
    end else begin
      if (m_rise) begin m_rcnt8 = sat_inc(m_rcnt8, 255); m_rcnt2 = sat_inc(m_rcnt2, 3); end
      if (m_fall) begin m_fcnt8 = sat_inc(m_fcnt8, 255); m_fcnt2 = sat_inc(m_fcnt2, 3); end
    end
  endtask

  task automatic check_all();
    check_val("state_a", state_a, m_state);
    check_val("level_a", level_a, (m_state == 2) ? 1 : 0);
    check_val("fault_a", fault_a, (m_state == 3) ? 1 : 0);
    check_val("rise_a",  rise_a,  m_rise);
    check_val("fall_a",  fall_a,  m_fall);
    check_val("rcnt_a",  rcnt_a,  m_rcnt8);
    check_val("fcnt_a",  fcnt_a,  m_fcnt8);
    check_val("state_b", state_b, m_state);
    check_val("rise_b",  rise_b,  m_rise);
    check_val("fall_b",  fall_b,  m_fall);
    check_val("rcnt_b",  rcnt_b,  m_rcnt2);
    check_val("fcnt_b",  fcnt_b,  m_fcnt2);
    check_val("excl_a",  {31'd0, rise_a & fall_a}, 0);
  endtask

  // One clock: model follows the edge, outputs compared 1 time unit later,
  // then return to the falling edge where the next inputs are driven.
  task automatic step();
    @(posedge c);
    if (!clrbar) model_reset();
    else         model_edge();
    #1;
    check_all();
    @(negedge c);
  endtask

  task automatic drive(input bit q, input bit qb, input int n);
    q_in    = q;
    qbar_in = qb;
    for (int i = 0; i < n; i++) step();
  endtask

  // Drop reset between edges and expect the outputs to clear at once.
  task automatic async_reset();
    #3;
    clrbar = 1'b0;
    #1;
    model_reset();
    check_all();
    check_val("async_state", state_a, 0);
    step();
    clrbar = 1'b1;
  endtask

  initial begin
    clrbar  = 1'b0;
    q_in    = 1'b1;
    qbar_in = 1'b0;
    cnt_clr = 1'b0;
    model_reset();
    @(negedge c);
    step();
    step();
    clrbar = 1'b1;

    // Reset release with a high latch: HIGH appears on the third edge.
    step();
    check_val("rel_e1_state", state_a, 0);
    step();
    check_val("rel_e2_state", state_a, 0);
    step();
    check_val("rel_e3_state", state_a, 2);
    check_val("rel_e3_rise",  rise_a, 0);
    drive(1, 0, 4);

    // Four level changes, ten cycles each.
    for (int i = 0; i < 4; i++) drive(i[0], !i[0], 10);
    check_val("tog_fcnt", fcnt_a, 2);
    check_val("tog_rcnt", rcnt_a, 2);

    // Short invalid burst is tolerated, a long one faults.
    drive(1, 1, 2);
    drive(1, 0, 6);
    check_val("burst_fault", fault_a, 0);
    drive(1, 1, 3);
    drive(1, 0, 2);
    check_val("long_fault", state_a, 3);
    drive(0, 1, 5);
    drive(1, 0, 5);
    check_val("fault_hold", fault_a, 1);

    // Clear out of FAULT, then a valid pair re-enters without a pulse.
    cnt_clr = 1'b1;
    step();
    cnt_clr = 1'b0;
    check_val("clr_state", state_a, 0);
    check_val("clr_rcnt",  rcnt_a, 0);
    drive(0, 1, 6);
    check_val("reenter_state", state_a, 1);

    // Five rises saturate the narrow counter.
    for (int i = 0; i < 5; i++) begin
      drive(1, 0, 4);
      drive(0, 1, 4);
    end
    check_val("sat_rcnt_b", rcnt_b, 3);
    check_val("sat_rcnt_a", rcnt_a, 5);

    // Clear coincident with a rise: pulse survives, count reads zero.
    q_in = 1'b1; qbar_in = 1'b0;
    step();
    step();
    cnt_clr = 1'b1;
    step();
    cnt_clr = 1'b0;
    check_val("coin_rise", rise_a, 1);
    check_val("coin_rcnt", rcnt_a, 0);
    drive(1, 0, 3);

    // Asynchronous reset in the middle of toggling.
    drive(0, 1, 2);
    async_reset();
    drive(0, 1, 6);

    // Randomized latch activity with occasional invalid pairs and clears.
    for (int seg = 0; seg < 200; seg++) begin
      int r, len;
      bit q, qb;
      r = $urandom_range(0, 9);
      if (r < 4)       begin q = 1; qb = 0; end
      else if (r < 8)  begin q = 0; qb = 1; end
      else if (r == 8) begin q = 0; qb = 0; end
      else             begin q = 1; qb = 1; end
      len = $urandom_range(1, 8);
      q_in = q;
      qbar_in = qb;
      for (int k = 0; k < len; k++) begin
        cnt_clr = ($urandom_range(0, 19) == 0);
        step();
      end
      cnt_clr = 1'b0;
      if (seg % 50 == 49) async_reset();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
